mul_sequencer: RTL

Iterative multi-cycle multiplier with its own sequencing FSM. It serves the multicycle ARM core's MUL, UMULL and SMULL instructions. The controller holds the core in its execute state while `busy` is high, then writes back `result_lo` (Rd, or RdLo) and `result_hi` (RdHi) once `done` pulses. The radix-2 shift-add engine trades latency for area and keeps the 32x32 combinational multiplier off the ALU critical path.

---
 rtl/mul_sequencer_if.sv | 26 ++
 rtl/mul_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer_if.sv
// Request/result bundle between the core's multicycle controller and mul_sequencer.
interface mul_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             abort;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             flag_n;
   logic             flag_z;

   modport master (
      output start, abort, op, a, b,
      input  busy, done, result_lo, result_hi, flag_n, flag_z
   );

   modport slave (
      input  start, abort, op, a, b,
      output busy, done, result_lo, result_hi, flag_n, flag_z
   );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier for MUL/UMULL/SMULL: WIDTH steps, one sign-fix cycle, one done cycle.
module mul_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   mul_sequencer_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic               flag_n_q, flag_n_d;
   logic               flag_z_q, flag_z_d;

   logic [WIDTH-1:0]   addend_s;
   logic [WIDTH:0]     sum_s;
   logic [2*WIDTH-1:0] fixed_s;
   logic               is_long_s;

   // The most negative value maps onto 2^(WIDTH-1), which fits as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      if (v[WIDTH-1]) begin
         magnitude = ~v + WIDTH'(1'b1);
      end else begin
         magnitude = v;
      end
   endfunction

   assign addend_s  = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
   assign sum_s     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
   assign fixed_s   = neg_q ? (~acc_q + (2*WIDTH)'(1'b1)) : acc_q;
   assign is_long_s = (op_q != 2'b00);

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;

      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               state_d = S_IDLE;
               if (bus.start) begin
                  state_d = S_RUN;
                  op_d    = bus.op;
                  acc_d   = {(2*WIDTH){1'b0}};
                  cnt_d   = {CNT_W{1'b0}};
                  if (bus.op == 2'b10) begin
                     mcand_d  = magnitude(bus.a);
                     mplier_d = magnitude(bus.b);
                     neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  end else begin
                     mcand_d  = bus.a;
                     mplier_d = bus.b;
                     neg_d    = 1'b0;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_RUN: begin
               // Carry out of the add lands in the MSB after the shift.
               acc_d    = {sum_s, acc_q[WIDTH-1:1]};
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1'b1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_FIX: begin
               state_d  = S_DONE;
               res_lo_d = fixed_s[WIDTH-1:0];
               if (is_long_s) begin
                  res_hi_d = fixed_s[2*WIDTH-1:WIDTH];
                  flag_n_d = fixed_s[2*WIDTH-1];
                  flag_z_d = (fixed_s == {(2*WIDTH){1'b0}});
               end else begin
                  res_hi_d = {WIDTH{1'b0}};
                  flag_n_d = fixed_s[WIDTH-1];
                  flag_z_d = (fixed_s[WIDTH-1:0] == {WIDTH{1'b0}});
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d == S_RUN) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= 2'b00;
         neg_q    <= 1'b0;
         mcand_q  <= {WIDTH{1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         acc_q    <= {(2*WIDTH){1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         res_lo_q <= {WIDTH{1'b0}};
         res_hi_q <= {WIDTH{1'b0}};
         flag_n_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         flag_n_q <= flag_n_d;
         flag_z_q <= flag_z_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result_lo = res_lo_q;
   assign bus.result_hi = res_hi_q;
   assign bus.flag_n    = flag_n_q;
   assign bus.flag_z    = flag_z_q;
endmodule
